// File: rtl/reg_share_arbiter.sv
// reg_share_arbiter
// Round-robin arbiter sharing one W-bit register between N requesters.
// A requester may write the shared register only while it holds the grant.
// An owner that keeps its request is preempted after HOLD_MAX granted
// cycles, but only when some other requester is waiting.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no grant outstanding; owner keeps the last grantee index
// GRANT | gnt[owner] set; cnt counts granted cycles (saturating)

module reg_share_arbiter #(
    parameter  int N        = 4,
    parameter  int W        = 8,
    parameter  int HOLD_MAX = 8,
    localparam int OW       = $clog2(N),
    localparam int CW       = $clog2(HOLD_MAX)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [N-1:0]   wr,
    input  logic [N*W-1:0] wdata,
    output logic [N-1:0]   gnt,
    output logic [OW-1:0]  owner,
    output logic           busy,
    output logic [W-1:0]   q
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t        state;
    logic [OW-1:0] ptr;
    logic [CW-1:0] cnt;

    logic [N-1:0]  owner_mask;
    logic [N-1:0]  others;
    logic [OW-1:0] start_next;
    logic [OW-1:0] pick_idle;
    logic [OW-1:0] pick_next;
    logic          own_req;
    logic          hold_done;
    logic          handover;

    // First set bit of mask, scanning start, start+1, ... modulo N.
    function automatic logic [OW-1:0] rr_pick(input logic [N-1:0]  mask,
                                              input logic [OW-1:0] start);
        logic [OW-1:0] sel;
        logic [OW-1:0] idx;
        logic          found;
        sel   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = OW'((int'(start) + k) % N);
            if (!found && mask[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
        return sel;
    endfunction

    // Arbitration decisions derived from the current owner and requests.
    always_comb begin
        owner_mask = N'(1) << owner;
        others     = req & ~owner_mask;
        start_next = (owner == OW'(N - 1)) ? '0 : owner + 1'b1;
        pick_idle  = rr_pick(req, ptr);
        pick_next  = rr_pick(others, start_next);
        own_req    = |(req & owner_mask);
        hold_done  = (cnt == CW'(HOLD_MAX - 1));
        // Lose the grant on release, or on hold expiry with a contender.
        handover   = !own_req || (hold_done && (|others));
    end

    // Grant FSM: one-hot grant, owner index, priority pointer, hold counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            gnt   <= '0;
            owner <= '0;
            ptr   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        state <= GRANT;
                        gnt   <= N'(1) << pick_idle;
                        owner <= pick_idle;
                        cnt   <= '0;
                    end
                end
                GRANT: begin
                    if (handover) begin
                        ptr <= start_next;
                        cnt <= '0;
                        // Hand straight to the next waiter so no idle bubble appears.
                        if (|others) begin
                            gnt   <= N'(1) << pick_next;
                            owner <= pick_next;
                        end else begin
                            gnt   <= '0;
                            state <= IDLE;
                        end
                    end else if (!hold_done) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Shared register: only the current grantee's write lands, including on
    // the edge where it loses the grant. gnt is one-hot, so owner names it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (|(gnt & wr)) begin
            q <= wdata[owner*W +: W];
        end
    end

    assign busy = |gnt;

endmodule

// File: doc/reg_share_arbiter.md
# reg_share_arbiter

Round-robin arbiter that shares one W-bit register between N requesters. Each requester raises a request, gets a registered one-hot grant, and may write the shared register only while granted. A hold limit bounds how long one owner can monopolise the register. The block sits between requesting datapath units and the shared storage they write.

## Interface
- N, default 4: number of requesters (2..8).
- W, default 8: shared register width.
- HOLD_MAX, default 8: maximum grant cycles before preemption when others wait (≥2).

- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset; one clock, reset asynchronous active-low.
- req  in  N  per-requester request, level-sensitive.
- wr  in  N  per-requester write strobe; honoured only with matching gnt bit.
- wdata  in  N*W  packed write data; slice i = wdata[i*W +: W].
- gnt  out  N  registered one-hot grant (all-zero when idle).
- owner  out  clog2(N)  index of current grantee; holds last value when idle.
- busy  out  1  high while any gnt bit is set.
- q  out  W  shared register contents.

## Operation
- Reset (rst low, any time, asynchronous): gnt=0, owner=0, busy=0, q=0, priority pointer ptr=0, hold counter cnt=0, FSM=IDLE.
- FSM states: IDLE, GRANT.
- IDLE: if req≠0 at a rising edge, grant the first set bit searching ptr, ptr+1, … (mod N); go to GRANT, cnt=0.
- GRANT, owner o:
  - req[o] low at edge -> release. If other req bits set, grant next in round-robin order starting at o+1 (mod N) at that same edge (no idle bubble), cnt=0; else gnt=0, go IDLE.
  - req[o] high, cnt==HOLD_MAX-1, another req bit set -> preempt: grant next requester from o+1 (mod N), cnt=0.
  - req[o] high otherwise -> keep grant; cnt increments, saturating at HOLD_MAX-1.
- ptr updates to (o+1) mod N whenever owner o loses grant (release or preempt).
- A requester is never granted twice in a row while another is waiting at the handover edge.
- Write: at rising edge, if gnt[i] and wr[i], q <= wdata slice i. wr from non-granted requesters is ignored. Write in the final granted cycle (release/preempt edge) is still performed.
- q holds its value when no write occurs; busy = |gnt.

## Timing
- Request to grant: 1 cycle (req sampled at edge k, gnt visible after edge k).
- Write latency: 1 cycle (gnt&wr at edge k -> q updated after edge k).
- Handover: gnt moves from o to next owner at the single edge where release/preempt is decided; gnt remains one-hot, never two bits set.
- Max wait for any requester with continuous req: (N-1)*HOLD_MAX cycles after its req is sampled.
- Reset mid-operation: outputs go to reset values immediately on rst low, regardless of clk; first grant possible at first rising edge after rst goes high.
- Release and new request on same edge: new request participates in that edge's arbitration.

## Test plan
- Reset: drive rst low mid-grant with q=0xA5 -> gnt=0, busy=0, owner=0, q=0x00 immediately, before next clk edge.
- Single requester: req=0b0100, wr[2]=1, wdata slice2=0x3C -> gnt=0b0100 one cycle later, q=0x3C next cycle; drop req -> gnt=0, busy=0 next cycle.
- Round-robin: req=0b1111 held, each owner drops req after 2 cycles then reasserts -> grant order 0,1,2,3,0 with no idle cycle between grants.
- Preemption: req[0] held continuously, req[1] raised at cycle 3 of grant 0 -> gnt switches to 0b0010 exactly after HOLD_MAX (8) cycles of grant 0; req[0] alone (no contenders) -> grant kept indefinitely.
- Write filtering: gnt=0b0001, wr=0b0110 with wdata slices 0x11/0x22 -> q unchanged; wr[0]=1 with 0x77 -> q=0x77.
- Last-cycle write: owner drops req and pulses wr with 0x5A on the release edge while req[3] pending -> q=0x5A and gnt=0b1000 after that same edge.
